time_register: RTL and testbench

//  Time-of-day register: hours/minutes/seconds counter advanced by the 1 Hz strobe from clk_gen.

---
 rtl/time_register.sv | 121 ++++++++++++
 tb/tb_time_register.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/time_register.sv
// rtl/time_register.sv - time-of-day hours/minutes/seconds register with button-driven set modes
module time_register #(
    parameter int RESET_HOURS   = 0,
    parameter int RESET_MINUTES = 0,
    parameter int RESET_SECONDS = 0
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_1hz_stb,
    input  logic       i_slow_set_stb,
    input  logic       i_fast_set_stb,
    input  logic       i_fast_set,
    input  logic       i_set_hours,
    input  logic       i_set_minutes,
    output logic [4:0] o_hours,
    output logic [5:0] o_minutes,
    output logic [5:0] o_seconds,
    output logic       o_set_active,
    output logic       o_day_stb
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_SET_MIN = 2'd1;
    localparam logic [1:0] ST_SET_HR  = 2'd2;

    logic [1:0] state_q, state_d;
    logic [4:0] hours_q, hours_d;
    logic [5:0] minutes_q, minutes_d;
    logic [5:0] seconds_q, seconds_d;
    logic       set_active_q;
    logic       day_stb_q, day_stb_d;

    logic       set_stb;
    logic       sec_wrap, min_wrap, hr_wrap;
    logic [5:0] sec_inc, min_inc;
    logic [4:0] hr_inc;

    // Mode follows the button levels; conflicting or released buttons mean RUN.
    always_comb begin
        state_d = ST_RUN;
        if (i_set_hours && !i_set_minutes) begin
            state_d = ST_SET_HR;
        end else if (i_set_minutes && !i_set_hours) begin
            state_d = ST_SET_MIN;
        end
    end

    // Field increments; >= so that an out-of-range value (bad parameter) wraps to 0.
    always_comb begin
        set_stb  = i_fast_set ? i_fast_set_stb : i_slow_set_stb;
        sec_wrap = (seconds_q >= 6'd59);
        min_wrap = (minutes_q >= 6'd59);
        hr_wrap  = (hours_q >= 5'd23);
        sec_inc  = sec_wrap ? 6'd0 : 6'(seconds_q + 6'd1);
        min_inc  = min_wrap ? 6'd0 : 6'(minutes_q + 6'd1);
        hr_inc   = hr_wrap ? 5'd0 : 5'(hours_q + 5'd1);
    end

    // Next time value: only the action of the current mode applies.
    always_comb begin
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        day_stb_d = 1'b0;
        case (state_q)
            ST_SET_MIN: begin
                seconds_d = 6'd0;
                if (set_stb) begin
                    minutes_d = min_inc;
                end
            end
            ST_SET_HR: begin
                seconds_d = 6'd0;
                if (set_stb) begin
                    hours_d = hr_inc;
                end
            end
            ST_RUN: begin
                if (i_1hz_stb) begin
                    seconds_d = sec_inc;
                    if (sec_wrap) begin
                        minutes_d = min_inc;
                        if (min_wrap) begin
                            hours_d   = hr_inc;
                            day_stb_d = hr_wrap;
                        end
                    end
                end
            end
            default: begin
                seconds_d = 6'd0;
            end
        endcase
    end

    // State and output registers; reset loads the configured time of day.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q      <= ST_RUN;
            hours_q      <= 5'(RESET_HOURS);
            minutes_q    <= 6'(RESET_MINUTES);
            seconds_q    <= 6'(RESET_SECONDS);
            set_active_q <= 1'b0;
            day_stb_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hours_q      <= hours_d;
            minutes_q    <= minutes_d;
            seconds_q    <= seconds_d;
            set_active_q <= (state_d != ST_RUN);
            day_stb_q    <= day_stb_d;
        end
    end

    assign o_hours      = hours_q;
    assign o_minutes    = minutes_q;
    assign o_seconds    = seconds_q;
    assign o_set_active = set_active_q;
    assign o_day_stb    = day_stb_q;

endmodule

// File: tb/tb_time_register.sv
// tb/tb_time_register.sv - scoreboard bench for time_register against a seconds-of-day model
module tb_time_register;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hz = 1'b0, slow = 1'b0, fast = 1'b0, fsel = 1'b0;
    logic       btn_h = 1'b0, btn_m = 1'b0;
    logic [4:0] o_hours;
    logic [5:0] o_minutes, o_seconds;
    logic       o_set_active, o_day_stb;

    always #5 clk = ~clk;

    time_register #(
        .RESET_HOURS(23), .RESET_MINUTES(59), .RESET_SECONDS(58)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_1hz_stb(hz),
        .i_slow_set_stb(slow), .i_fast_set_stb(fast), .i_fast_set(fsel),
        .i_set_hours(btn_h), .i_set_minutes(btn_m),
        .o_hours(o_hours), .o_minutes(o_minutes), .o_seconds(o_seconds),
        .o_set_active(o_set_active), .o_day_stb(o_day_stb)
    );

    // Reference model: time held as seconds since midnight, mode 0=run 1=set-min 2=set-hr.
    int  m_t    = 0;
    int  m_mode = 0;
    bit  m_act  = 0;
    bit  m_day  = 0;
    logic [18:0] exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc    = 0;
    bit  drv_done = 0;
    int  drain  = 0;

    function automatic logic [18:0] pack_exp();
        int h, m, s;
        h = m_t / 3600;
        m = (m_t / 60) % 60;
        s = m_t % 60;
        return {5'(h), 6'(m), 6'(s), m_act, m_day};
    endfunction

    task automatic model_step();
        int  h, m;
        bit  stb;
        if (!rst_n) begin
            m_t    = 23 * 3600 + 59 * 60 + 58;
            m_mode = 0;
            m_act  = 0;
            m_day  = 0;
        end else begin
            stb   = fsel ? fast : slow;
            m_day = 0;
            h = m_t / 3600;
            m = (m_t / 60) % 60;
            if (m_mode == 0) begin
                if (hz) begin
                    m_t   = (m_t + 1) % 86400;
                    m_day = (m_t == 0);
                end
            end else if (m_mode == 1) begin
                if (stb) m = (m + 1) % 60;
                m_t = h * 3600 + m * 60;
            end else begin
                if (stb) h = (h + 1) % 24;
                m_t = h * 3600 + m * 60;
            end
            m_mode = (btn_h && !btn_m) ? 2 : ((btn_m && !btn_h) ? 1 : 0);
            m_act  = (m_mode != 0);
        end
    endtask

    // One clock of stimulus: drive, let the edge happen, push the model's expectation.
    task automatic tick(input logic r, input logic h1, input logic s1, input logic f1);
        rst_n = r; hz = h1; slow = s1; fast = f1;
        @(posedge clk);
        model_step();
        exp_q.push_back(pack_exp());
        @(negedge clk);
        rst_n = 1'b1; hz = 1'b0; slow = 1'b0; fast = 1'b0;
    endtask

    // Monitor: the registered outputs are presented every cycle; compare at the falling edge.
    always @(negedge clk) begin
        logic [18:0] e, g;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {o_hours, o_minutes, o_seconds, o_set_active, o_day_stb};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL outputs cycle %0d: got %0d:%0d:%0d act=%0b day=%0b want %0d:%0d:%0d act=%0b day=%0b",
                         cyc, g[18:14], g[13:8], g[7:2], g[1], g[0],
                         e[18:14], e[13:8], e[7:2], e[1], e[0]);
            end
        end else if (drv_done) begin
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
        if (drv_done && exp_q.size() > 0) begin
            drain++;
            if (drain > 10) begin
                errors++;
                checks++;
                $display("FAIL drain timeout: got %0d pending want 0", exp_q.size());
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    initial begin
        @(negedge clk);
        tick(0, 0, 0, 0);
        tick(0, 1, 1, 1);
        // Roll over midnight: 23:59:58 -> 23:59:59 -> 00:00:00 with day strobe.
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);
        tick(1, 0, 0, 0);
        // One hour of seconds.
        repeat (3600) tick(1, 1, 0, 0);
        tick(1, 0, 0, 0);
        // Set hours 1 -> 10 with slow steps.
        btn_h = 1;
        tick(1, 0, 0, 0);
        repeat (9) begin tick(1, 0, 1, 0); tick(1, 1, 0, 0); end
        btn_h = 0;
        // Set minutes 0 -> 59.
        btn_m = 1;
        tick(1, 0, 0, 0);
        repeat (59) tick(1, 0, 1, 0);
        btn_m = 0;
        tick(1, 0, 0, 0);
        repeat (30) tick(1, 1, 0, 0);
        // 10:59:30: minutes set, first strobe coincides with entry and is ignored.
        btn_m = 1;
        tick(1, 1, 1, 0);
        repeat (3) begin tick(1, 0, 1, 0); tick(1, 1, 0, 0); end
        // 1 Hz and set strobe together in SET_MIN.
        tick(1, 1, 1, 0);
        btn_m = 0;
        tick(1, 0, 0, 0);
        tick(1, 1, 0, 0);
        // Fast hours set: to 20, slow strobes ignored, then 8 more -> 4.
        fsel = 1; btn_h = 1;
        tick(1, 0, 0, 0);
        repeat (10) tick(1, 0, 0, 1);
        repeat (4) tick(1, 1, 1, 0);
        repeat (8) begin tick(1, 0, 0, 1); tick(1, 0, 0, 0); end
        // Both buttons -> RUN.
        btn_m = 1;
        tick(1, 0, 0, 1);
        tick(1, 1, 0, 0);
        // Reset mid SET_HR with the button still held.
        btn_m = 0;
        tick(1, 0, 0, 1);
        tick(0, 0, 0, 1);
        tick(1, 0, 0, 1);
        tick(1, 0, 0, 1);
        btn_h = 0; fsel = 0;
        tick(1, 0, 0, 0);
        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            if (i % 17 == 0) begin
                btn_h = 1'($urandom_range(0, 1));
                btn_m = 1'($urandom_range(0, 1));
                fsel  = 1'($urandom_range(0, 1));
            end
            tick(($urandom_range(0, 150) != 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0));
        end
        drv_done = 1;
    end

endmodule
